// File: rtl/act_sched_pkg.sv
// Shared types and helpers for the activation scheduler.
// Holds the FSM state enum, ID width helper and round-robin pick.
package act_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Upper bound on requesters handled by rr_pick.
    localparam int MAX_REQ = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First valid requester at or after ptr, wrapping modulo n.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic int rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        int   win;
        int   idx;
        logic found;
        win   = 0;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (!found && valid[idx[4:0]]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/activation_scheduler_id_fifo.sv
// In-order FIFO of granted requester IDs (sched_id_fifo).
// Ports: clk, reset (sync, low), push/din, pop/dout, full, empty.
module sched_id_fifo
    import act_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           AW  = $clog2(DEPTH);
    localparam logic [AW:0]  ONE = (AW+1)'(1);

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_we;
    logic             w_re;

    // Extra pointer MSB separates full (MSBs differ) from empty.
    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_we  = push && !full;
    assign w_re  = pop && !empty;
    assign dout  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_we) r_wr <= r_wr + ONE;
            if (w_re) r_rd <= r_rd + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/activation_scheduler.sv
// Shares one activation unit between NUM_REQ AXI-stream requesters.
// Ports: s_axis_* requester inputs, act_s/act_m_* activation unit,
//        m_axis_* per-requester returns, grant_id, busy, err_orphan.
module activation_scheduler
    import act_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid,
    output logic [NUM_REQ-1:0]            s_axis_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]            s_axis_tlast,
    output logic                          act_s_axis_tvalid,
    input  logic                          act_s_axis_tready,
    output logic [DATA_WIDTH-1:0]         act_s_axis_tdata,
    output logic                          act_s_axis_tlast,
    input  logic                          act_m_axis_tvalid,
    output logic                          act_m_axis_tready,
    input  logic [DATA_WIDTH-1:0]         act_m_axis_tdata,
    input  logic                          act_m_axis_tlast,
    output logic [NUM_REQ-1:0]            m_axis_tvalid,
    input  logic [NUM_REQ-1:0]            m_axis_tready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_REQ-1:0]            m_axis_tlast,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          err_orphan
);

    localparam int             IDW     = id_w(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [IDW-1:0] ID_ONE  = IDW'(1);

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant_id;
    logic           r_err_orphan;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_head;
    logic           w_any_valid;
    logic           w_push;
    logic           w_pop;
    logic           w_done;
    logic           w_full;
    logic           w_empty;

    assign w_any_valid = |s_axis_tvalid;
    assign w_winner    = IDW'(rr_pick(MAX_REQ'(s_axis_tvalid),
                                      int'(r_rr_ptr), NUM_REQ));

    sched_id_fifo #(
        .DEPTH (ID_DEPTH),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_winner),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Arbitration and forward mux.
    always_comb begin
        w_next            = r_state;
        w_push            = 1'b0;
        w_done            = 1'b0;
        s_axis_tready     = '0;
        act_s_axis_tvalid = 1'b0;
        act_s_axis_tdata  = '0;
        act_s_axis_tlast  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Grant only if the result's ID has a FIFO slot.
                if (w_any_valid && !w_full) begin
                    w_push = 1'b1;
                    w_next = BUSY;
                end
            end
            BUSY: begin
                act_s_axis_tvalid = s_axis_tvalid[r_grant_id];
                act_s_axis_tdata  =
                    s_axis_tdata[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
                act_s_axis_tlast  = s_axis_tlast[r_grant_id];
                s_axis_tready[r_grant_id] = act_s_axis_tready;
                if (act_s_axis_tvalid && act_s_axis_tready &&
                    act_s_axis_tlast) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Return demux steered by the oldest outstanding ID.
    always_comb begin
        m_axis_tvalid     = '0;
        act_m_axis_tready = 1'b0;
        w_pop             = 1'b0;
        if (!w_empty) begin
            m_axis_tvalid[w_head] = act_m_axis_tvalid;
            act_m_axis_tready     = m_axis_tready[w_head];
            w_pop = act_m_axis_tvalid && m_axis_tready[w_head] &&
                    act_m_axis_tlast;
        end
    end

    assign m_axis_tdata = {NUM_REQ{act_m_axis_tdata}};
    assign m_axis_tlast = {NUM_REQ{act_m_axis_tlast}};
    assign grant_id     = r_grant_id;
    assign busy         = (r_state == BUSY);
    assign err_orphan   = r_err_orphan;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) r_grant_id <= w_winner;
            if (w_done) begin
                r_rr_ptr <= (r_grant_id == LAST_ID) ? '0
                                                    : r_grant_id + ID_ONE;
            end
            if (w_empty && act_m_axis_tvalid) r_err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench for activation_scheduler with a behavioural ReLU unit.
// Requester sources, ReLU model and return logging are bench processes.
module tb_activation_scheduler;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int IDD = 2;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    s_axis_tvalid = '0;
    logic [NR-1:0]    s_axis_tready;
    logic [NR*DW-1:0] s_axis_tdata  = '0;
    logic [NR-1:0]    s_axis_tlast  = '0;
    logic             act_s_axis_tvalid;
    logic             act_s_axis_tready = 1'b1;
    logic [DW-1:0]    act_s_axis_tdata;
    logic             act_s_axis_tlast;
    logic             act_m_axis_tvalid = 1'b0;
    logic             act_m_axis_tready;
    logic [DW-1:0]    act_m_axis_tdata  = '0;
    logic             act_m_axis_tlast  = 1'b0;
    logic [NR-1:0]    m_axis_tvalid;
    logic [NR-1:0]    m_axis_tready = '1;
    logic [NR*DW-1:0] m_axis_tdata;
    logic [NR-1:0]    m_axis_tlast;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err_orphan;

    logic [DW:0] src [NR][$];
    logic [DW:0] rx  [NR][$];
    logic [DW:0] q   [$];
    int          glog [$];
    int          seen_cnt [NR];

    logic [NR-1:0] s_fire     = '0;
    logic          a_in_fire  = 1'b0;
    logic          a_out_fire = 1'b0;
    logic [DW:0]   a_in_beat  = '0;
    logic          busy_prev  = 1'b0;
    logic          force_orphan = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    activation_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_DEPTH   (IDD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .act_s_axis_tvalid (act_s_axis_tvalid),
        .act_s_axis_tready (act_s_axis_tready),
        .act_s_axis_tdata  (act_s_axis_tdata),
        .act_s_axis_tlast  (act_s_axis_tlast),
        .act_m_axis_tvalid (act_m_axis_tvalid),
        .act_m_axis_tready (act_m_axis_tready),
        .act_m_axis_tdata  (act_m_axis_tdata),
        .act_m_axis_tlast  (act_m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tlast      (m_axis_tlast),
        .grant_id          (grant_id),
        .busy              (busy),
        .err_orphan        (err_orphan)
    );

    // Mid-cycle sampling: inputs only move just after posedge.
    always @(negedge clk) begin
        s_fire     <= s_axis_tvalid & s_axis_tready;
        a_in_fire  <= act_s_axis_tvalid && act_s_axis_tready;
        a_in_beat  <= {act_s_axis_tlast,
                       act_s_axis_tdata[DW-1] ? {DW{1'b0}}
                                              : act_s_axis_tdata};
        a_out_fire <= act_m_axis_tvalid && act_m_axis_tready;
        busy_prev  <= busy;
        if (reset) begin
            if (busy && !busy_prev) glog.push_back(int'(grant_id));
            for (int i = 0; i < NR; i++) begin
                if (m_axis_tvalid[i]) seen_cnt[i] = seen_cnt[i] + 1;
                if (m_axis_tvalid[i] && m_axis_tready[i])
                    rx[i].push_back({m_axis_tlast[i],
                                     m_axis_tdata[i*DW +: DW]});
            end
        end
    end

    // ReLU activation unit: always ready, in-order result queue.
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
        end else begin
            if (a_out_fire && q.size() != 0) void'(q.pop_front());
            if (a_in_fire) q.push_back(a_in_beat);
        end
        act_m_axis_tvalid <= (q.size() != 0) || force_orphan;
        act_m_axis_tdata  <= (q.size() != 0) ? q[0][DW-1:0] : '0;
        act_m_axis_tlast  <= (q.size() != 0) && q[0][DW];
    end

    // Requester sources replay their beat queues.
    always begin
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (s_fire[r] && src[r].size() != 0)
                void'(src[r].pop_front());
            if (src[r].size() != 0) begin
                s_axis_tvalid[r]           = 1'b1;
                s_axis_tdata[r*DW +: DW]   = src[r][0][DW-1:0];
                s_axis_tlast[r]            = src[r][0][DW];
            end else begin
                s_axis_tvalid[r]           = 1'b0;
                s_axis_tdata[r*DW +: DW]   = '0;
                s_axis_tlast[r]            = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: no finish after 400us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NR; i++) begin
            rx[i].delete();
            seen_cnt[i] = 0;
        end
        glog.delete();
    endtask

    task automatic wait_rx(input int r, input int n);
        for (int k = 0; k < 60 && rx[r].size() < n; k++) step(1);
    endtask

    task automatic wait_glog(input int n);
        for (int k = 0; k < 60 && glog.size() < n; k++) step(1);
    endtask

    function automatic logic [DW:0] beat(input logic l,
                                         input logic [DW-1:0] d);
        return {l, d};
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) seen_cnt[i] = 0;
        step(2);
        reset = 1'b1;

        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_act_s_tvalid", 64'(act_s_axis_tvalid), 64'd0);
        check("rst_act_m_tready", 64'(act_m_axis_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_orphan), 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);

        // 1: single requester, ReLU clamps the negative beat
        clear_logs();
        src[0].push_back(beat(1'b0, 32'h0000_0010));
        src[0].push_back(beat(1'b1, 32'h8000_0010));
        wait_rx(0, 2);
        check("t1_cnt", 64'(rx[0].size()), 64'd2);
        check("t1_b0", 64'(rx[0][0]), 64'(beat(1'b0, 32'h10)));
        check("t1_b1", 64'(rx[0][1]), 64'(beat(1'b1, 32'h0)));
        check("t1_other_vld",
              64'(seen_cnt[1] + seen_cnt[2] + seen_cnt[3]), 64'd0);
        check("t1_gid", 64'(grant_id), 64'd0);

        // 2: simultaneous requests after reset, then rr_ptr==2
        do_reset();
        clear_logs();
        src[0].push_back(beat(1'b0, 32'h1));
        src[0].push_back(beat(1'b1, 32'h2));
        src[1].push_back(beat(1'b1, 32'h3));
        wait_rx(1, 1);
        wait_rx(0, 2);
        check("t2_ngrant", 64'(glog.size()), 64'd2);
        check("t2_g0", 64'(glog[0]), 64'd0);
        check("t2_g1", 64'(glog[1]), 64'd1);
        check("t2_r0b0", 64'(rx[0][0]), 64'(beat(1'b0, 32'h1)));
        check("t2_r0b1", 64'(rx[0][1]), 64'(beat(1'b1, 32'h2)));
        check("t2_r1b0", 64'(rx[1][0]), 64'(beat(1'b1, 32'h3)));
        clear_logs();
        src[1].push_back(beat(1'b1, 32'h4));
        src[2].push_back(beat(1'b1, 32'h5));
        wait_rx(1, 1);
        wait_rx(2, 1);
        check("t2_ptr_g0", 64'(glog[0]), 64'd2);
        check("t2_ptr_g1", 64'(glog[1]), 64'd1);
        check("t2_r2", 64'(rx[2][0]), 64'(beat(1'b1, 32'h5)));

        // 3: return backpressure on requester 1
        clear_logs();
        m_axis_tready = 4'b1101;
        src[1].push_back(beat(1'b0, 32'h11));
        src[1].push_back(beat(1'b0, 32'h12));
        src[1].push_back(beat(1'b1, 32'h13));
        for (int k = 0; k < 40 && !m_axis_tvalid[1]; k++) step(1);
        check("t3_vld", 64'(m_axis_tvalid[1]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("t3_stall", 64'(act_m_axis_tready), 64'd0);
            step(1);
        end
        check("t3_none", 64'(rx[1].size()), 64'd0);
        m_axis_tready = '1;
        wait_rx(1, 3);
        check("t3_cnt", 64'(rx[1].size()), 64'd3);
        check("t3_b0", 64'(rx[1][0]), 64'(beat(1'b0, 32'h11)));
        check("t3_b1", 64'(rx[1][1]), 64'(beat(1'b0, 32'h12)));
        check("t3_b2", 64'(rx[1][2]), 64'(beat(1'b1, 32'h13)));

        // 4: ID FIFO full (depth 2) blocks the third grant
        do_reset();
        clear_logs();
        m_axis_tready = '0;
        src[0].push_back(beat(1'b1, 32'h21));
        src[1].push_back(beat(1'b1, 32'hFFFF_FFFF));
        src[2].push_back(beat(1'b1, 32'h7FFF_FFFF));
        step(15);
        check("t4_ngrant", 64'(glog.size()), 64'd2);
        check("t4_g0", 64'(glog[0]), 64'd0);
        check("t4_g1", 64'(glog[1]), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_waiting", 64'(s_axis_tvalid[2]), 64'd1);
        check("t4_m_vld", 64'(m_axis_tvalid), 64'd1);
        check("t4_act_rdy", 64'(act_m_axis_tready), 64'd0);
        m_axis_tready = 4'b0001;
        wait_glog(3);
        check("t4_g2", 64'(glog[2]), 64'd2);
        check("t4_r0", 64'(rx[0][0]), 64'(beat(1'b1, 32'h21)));
        m_axis_tready = '1;
        wait_rx(2, 1);
        check("t4_r1", 64'(rx[1][0]), 64'(beat(1'b1, 32'h0)));
        check("t4_r2", 64'(rx[2][0]), 64'(beat(1'b1, 32'h7FFF_FFFF)));

        // 5: reset in the middle of requester 3's packet
        clear_logs();
        src[3].push_back(beat(1'b0, 32'h31));
        src[3].push_back(beat(1'b0, 32'h32));
        step(10);
        check("t5_pre_busy", 64'(busy), 64'd1);
        check("t5_pre_gid", 64'(grant_id), 64'd3);
        do_reset();
        check("t5_s_tready", 64'(s_axis_tready), 64'd0);
        check("t5_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_act_s_vld", 64'(act_s_axis_tvalid), 64'd0);
        check("t5_act_m_rdy", 64'(act_m_axis_tready), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        clear_logs();
        src[3].push_back(beat(1'b1, 32'h33));
        src[0].push_back(beat(1'b1, 32'h34));
        wait_rx(3, 1);
        check("t5_g0", 64'(glog[0]), 64'd0);
        check("t5_g1", 64'(glog[1]), 64'd3);
        check("t5_r0", 64'(rx[0][0]), 64'(beat(1'b1, 32'h34)));
        check("t5_r3", 64'(rx[3][0]), 64'(beat(1'b1, 32'h33)));

        // 6: result with no outstanding ID
        check("t6_err_pre", 64'(err_orphan), 64'd0);
        force_orphan = 1'b1;
        step(3);
        check("t6_err_set", 64'(err_orphan), 64'd1);
        check("t6_act_rdy", 64'(act_m_axis_tready), 64'd0);
        check("t6_m_vld", 64'(m_axis_tvalid), 64'd0);
        force_orphan = 1'b0;
        step(3);
        check("t6_err_sticky", 64'(err_orphan), 64'd1);
        do_reset();
        check("t6_err_clr", 64'(err_orphan), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
